piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//  Parametrised parallel-in/serial-out serializer with a valid/ready load port.
//  A one-word holding buffer sits in front of the shift register, so back-to-back words
//  stream out without gaps. Bit order is selectable. Shifting is paced by a bit-rate tick
//  (shift_en). Sits between a word producer (FIFO/CPU reg) and a serial line driver.
// PARAMETERS
//  WIDTH       8  bits per word; legal range >= 2
//  LSB_FIRST   0  0: bit WIDTH-1 sent first; 1: bit 0 sent first
//  IDLE_LEVEL  0  serial_out level when no frame is active
// PORTS
//  clk           in   1      single clock, rising edge
//  rst_n         in   1      asynchronous, active-low reset
//  clr           in   1      synchronous clear; same end state as reset
//  shift_en      in   1      bit-rate tick; serial outputs advance only when 1
//  load_valid    in   1      producer has a word on load_data
//  load_ready    out  1      holding buffer empty; word accepted when valid&ready
//  load_data     in   WIDTH  parallel word
//  serial_out    out  1      serial data, registered
//  serial_valid  out  1      serial_out carries a data bit
//  frame_start   out  1      serial_out is the first bit of a word
//  frame_end     out  1      serial_out is the last bit of a word
//  busy          out  1      shifter active or holding buffer full
// BEHAVIOUR
//  Reset / clr: hold_full=0, state=IDLE, bit_cnt=0.
//   Outputs: load_ready=1, serial_out=IDLE_LEVEL, serial_valid=0, frame_start=0,
//   frame_end=0, busy=0. clr has priority over all other inputs.
//  Load: load_ready = !hold_full (state only, no combinational path from inputs).
//   On valid&ready, hold <= load_data and hold_full <= 1. load_data is ignored otherwise.
//  State machine: IDLE, SHIFT. bit_cnt is $clog2(WIDTH) bits wide.
//   Outputs and state change only on cycles with shift_en=1; between ticks all outputs hold.
//  Tick in SHIFT with bit_cnt < WIDTH-1:
//   - drive the next bit in the selected order; bit_cnt++.
//   - frame_start=0; frame_end=(new bit_cnt==WIDTH-1).
//  Tick in IDLE, or in SHIFT with bit_cnt==WIDTH-1 (word boundary):
//   - if hold_full: shifter <= hold; hold_full <= 0; drive the first bit; bit_cnt=0.
//     Set serial_valid=1 and frame_start=1; frame_end=0; state=SHIFT.
//   - else: state=IDLE, serial_out=IDLE_LEVEL, serial_valid=frame_start=frame_end=0.
//  Latency: a word accepted at edge N is in hold from N; its first bit appears on
//   serial_out at the edge of the first shift_en tick cycle after N (min 1 clk).
//  Gapless streaming: a word accepted before the last-bit tick of the current word
//   starts on the next tick. A word accepted later leaves >=1 idle bit slot.
//  Simultaneous accept and hold->shifter transfer cannot occur (ready=0 while full).
//   The accept window reopens the cycle after transfer.
//  Data in hold is never overwritten. Producer stalls while load_ready=0.
//  busy = (state==SHIFT) | hold_full.
//  Reset or clr mid-frame: the partial word and the held word are discarded.
//   Outputs return to their reset values immediately (async for rst_n).
// TESTING
//  1 Reset: rst_n=0 mid-frame -> serial_out=IDLE_LEVEL, valid=0, load_ready=1, busy=0
//    without a clock edge.
//  2 MSB-first, shift_en=1 constant, load 8'hA5 -> bits 1,0,1,0,0,1,0,1;
//    frame_start on bit 0, frame_end on bit 7.
//  3 LSB_FIRST=1, load 8'h01 -> bits 1,0,0,0,0,0,0,0. Then serial_valid=0, serial_out=0.
//  4 Back-to-back 8'hFF then 8'h00, second accepted during first word -> 16 contiguous
//    valid bits, no idle slot. load_ready=0 from accept until the transfer tick.
//  5 shift_en every 4th cycle, WIDTH=12, word 12'h800 -> each bit held 4 clk.
//    Outputs frozen between ticks. Exactly 12 valid bit slots.
//  6 clr asserted at bit 3 with hold full -> next cycle idle outputs, load_ready=1.
//    The held word is never transmitted.

Source files
------------

// File: rtl/piso_serializer_if.sv
// Load-side handshake for the parallel-in/serial-out serializer.
// The producer drives the word and valid; the serializer returns ready.
interface piso_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with a one-word holding buffer in front of
// the shift register. A word waiting in hold is moved into the shifter on the
// word-boundary tick, so consecutive words stream out with no idle bit slot.
// All serial outputs advance only on shift_en ticks and hold between them.
module piso_serializer #(
  parameter int WIDTH      = 8,
  parameter bit LSB_FIRST  = 1'b0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr,
  input  logic  shift_en,
  piso_if.slave load,
  output logic  serial_out,
  output logic  serial_valid,
  output logic  frame_start,
  output logic  frame_end,
  output logic  busy
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic             r_hold_full, w_hold_full_nxt;
  logic             r_serial_out, w_serial_out_nxt;
  logic             r_serial_valid, w_serial_valid_nxt;
  logic             r_frame_start, w_frame_start_nxt;
  logic             r_frame_end, w_frame_end_nxt;
  logic             w_accept;
  logic             w_boundary;

  // Bit that leaves the word first in the selected order.
  function automatic logic first_bit(input logic [WIDTH-1:0] word);
    return LSB_FIRST ? word[0] : word[WIDTH-1];
  endfunction

  // Word with the bit just sent removed, next bit moved into the send position.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] word);
    return LSB_FIRST ? (word >> 1) : (word << 1);
  endfunction

  // Ready depends only on hold state; a full hold is never overwritten.
  assign w_accept        = load.load_valid & ~r_hold_full;
  assign w_boundary      = (r_state == S_IDLE) || (r_bit_cnt == LAST_BIT);
  assign load.load_ready = ~r_hold_full;
  assign busy            = (r_state == S_SHIFT) | r_hold_full;

  assign serial_out   = r_serial_out;
  assign serial_valid = r_serial_valid;
  assign frame_start  = r_frame_start;
  assign frame_end    = r_frame_end;

  // Next-state and next-output decode; everything holds unless a tick arrives.
  always_comb begin
    w_state_nxt        = r_state;
    w_bit_cnt_nxt      = r_bit_cnt;
    w_shift_nxt        = r_shift;
    w_hold_full_nxt    = r_hold_full;
    w_serial_out_nxt   = r_serial_out;
    w_serial_valid_nxt = r_serial_valid;
    w_frame_start_nxt  = r_frame_start;
    w_frame_end_nxt    = r_frame_end;

    if (w_accept) begin
      w_hold_full_nxt = 1'b1;
    end

    if (shift_en) begin
      if (w_boundary) begin
        if (r_hold_full) begin
          // Transfer cannot coincide with an accept: ready is low while full.
          w_state_nxt        = S_SHIFT;
          w_bit_cnt_nxt      = '0;
          w_shift_nxt        = advance(r_hold);
          w_hold_full_nxt    = 1'b0;
          w_serial_out_nxt   = first_bit(r_hold);
          w_serial_valid_nxt = 1'b1;
          w_frame_start_nxt  = 1'b1;
          w_frame_end_nxt    = 1'b0;
        end else begin
          w_state_nxt        = S_IDLE;
          w_bit_cnt_nxt      = '0;
          w_serial_out_nxt   = IDLE_LEVEL;
          w_serial_valid_nxt = 1'b0;
          w_frame_start_nxt  = 1'b0;
          w_frame_end_nxt    = 1'b0;
        end
      end else begin
        w_bit_cnt_nxt      = r_bit_cnt + 1'b1;
        w_shift_nxt        = advance(r_shift);
        w_serial_out_nxt   = first_bit(r_shift);
        w_serial_valid_nxt = 1'b1;
        w_frame_start_nxt  = 1'b0;
        w_frame_end_nxt    = (r_bit_cnt + 1'b1) == LAST_BIT;
      end
    end
  end

  // Control state and serial outputs; clr discards partial and held words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_bit_cnt      <= '0;
      r_hold_full    <= 1'b0;
      r_serial_out   <= IDLE_LEVEL;
      r_serial_valid <= 1'b0;
      r_frame_start  <= 1'b0;
      r_frame_end    <= 1'b0;
    end else if (clr) begin
      r_state        <= S_IDLE;
      r_bit_cnt      <= '0;
      r_hold_full    <= 1'b0;
      r_serial_out   <= IDLE_LEVEL;
      r_serial_valid <= 1'b0;
      r_frame_start  <= 1'b0;
      r_frame_end    <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_bit_cnt      <= w_bit_cnt_nxt;
      r_hold_full    <= w_hold_full_nxt;
      r_serial_out   <= w_serial_out_nxt;
      r_serial_valid <= w_serial_valid_nxt;
      r_frame_start  <= w_frame_start_nxt;
      r_frame_end    <= w_frame_end_nxt;
    end
  end

  // Data path registers carry no reset; hold_full and state qualify them.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_hold <= load.load_data;
    end
    r_shift <= w_shift_nxt;
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: three instances cover MSB-first WIDTH=8,
// LSB-first WIDTH=8 and MSB-first WIDTH=12 with a slow bit-rate tick.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // Instance A: WIDTH=8, MSB first
  logic clr_a, sen_a, so_a, sv_a, fs_a, fe_a, busy_a;
  piso_if #(.WIDTH(8)) if_a();
  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr_a), .shift_en(sen_a), .load(if_a),
    .serial_out(so_a), .serial_valid(sv_a), .frame_start(fs_a),
    .frame_end(fe_a), .busy(busy_a)
  );

  // Instance B: WIDTH=8, LSB first
  logic clr_b, sen_b, so_b, sv_b, fs_b, fe_b, busy_b;
  piso_if #(.WIDTH(8)) if_b();
  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr_b), .shift_en(sen_b), .load(if_b),
    .serial_out(so_b), .serial_valid(sv_b), .frame_start(fs_b),
    .frame_end(fe_b), .busy(busy_b)
  );

  // Instance C: WIDTH=12, MSB first
  logic clr_c, sen_c, so_c, sv_c, fs_c, fe_c, busy_c;
  piso_if #(.WIDTH(12)) if_c();
  piso_serializer #(.WIDTH(12), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .clr(clr_c), .shift_en(sen_c), .load(if_c),
    .serial_out(so_c), .serial_valid(sv_c), .frame_start(fs_c),
    .frame_end(fe_c), .busy(busy_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_vec++;
    if ({so_a, sv_a, fs_a, fe_a, if_a.load_ready, busy_a} !== 6'b000010) begin
      n_err++;
      $display("FAIL reset_state: got %b want %b",
               {so_a, sv_a, fs_a, fe_a, if_a.load_ready, busy_a}, 6'b000010);
    end
    #2 rst_n = 1'b1;
    // Start A5, queue 5A in hold, stop at bit index 2 (a '1') then reset.
    sen_a = 1'b1;
    if_a.load_valid = 1'b1;
    if_a.load_data  = 8'hA5;
    tick();
    if_a.load_data = 8'h5A;
    tick();
    tick();
    if_a.load_valid = 1'b0;
    tick();
    n_vec++;
    if ({so_a, sv_a, if_a.load_ready, busy_a} !== 4'b1101) begin
      n_err++;
      $display("FAIL reset_preframe: got %b want %b",
               {so_a, sv_a, if_a.load_ready, busy_a}, 4'b1101);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({so_a, sv_a, fs_a, fe_a, if_a.load_ready, busy_a} !== 6'b000010) begin
      n_err++;
      $display("FAIL reset_async: got %b want %b",
               {so_a, sv_a, fs_a, fe_a, if_a.load_ready, busy_a}, 6'b000010);
    end
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_msb_first();
    logic [7:0] w = 8'hA5;
    sen_a = 1'b1;
    if_a.load_valid = 1'b1;
    if_a.load_data  = w;
    tick();
    if_a.load_valid = 1'b0;
    if_a.load_data  = 8'hFF;
    n_vec++;
    if ({sv_a, if_a.load_ready, busy_a} !== 3'b001) begin
      n_err++;
      $display("FAIL msb_accept: got %b want %b",
               {sv_a, if_a.load_ready, busy_a}, 3'b001);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      n_vec++;
      if ({so_a, sv_a, fs_a, fe_a} !== {w[7-i], 1'b1, i == 0, i == 7}) begin
        n_err++;
        $display("FAIL msb_bit%0d: got %b want %b", i,
                 {so_a, sv_a, fs_a, fe_a}, {w[7-i], 1'b1, i == 0, i == 7});
      end
    end
    tick();
    n_vec++;
    if ({so_a, sv_a, fs_a, fe_a, if_a.load_ready, busy_a} !== 6'b000010) begin
      n_err++;
      $display("FAIL msb_idle: got %b want %b",
               {so_a, sv_a, fs_a, fe_a, if_a.load_ready, busy_a}, 6'b000010);
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] w = 8'h01;
    sen_b = 1'b1;
    if_b.load_valid = 1'b1;
    if_b.load_data  = w;
    tick();
    if_b.load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_vec++;
      if ({so_b, sv_b, fs_b, fe_b} !== {w[i], 1'b1, i == 0, i == 7}) begin
        n_err++;
        $display("FAIL lsb_bit%0d: got %b want %b", i,
                 {so_b, sv_b, fs_b, fe_b}, {w[i], 1'b1, i == 0, i == 7});
      end
    end
    tick();
    n_vec++;
    if ({so_b, sv_b, busy_b} !== 3'b000) begin
      n_err++;
      $display("FAIL lsb_idle: got %b want %b", {so_b, sv_b, busy_b}, 3'b000);
    end
    sen_b = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic exp_bit, exp_rdy;
    sen_a = 1'b1;
    if_a.load_valid = 1'b1;
    if_a.load_data  = 8'hFF;
    tick();
    if_a.load_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k == 1) begin
        if_a.load_valid = 1'b1;
        if_a.load_data  = 8'h00;
      end
      tick();
      if_a.load_valid = 1'b0;
      exp_bit = (k < 8);
      exp_rdy = !(k >= 1 && k <= 7);
      n_vec++;
      if ({so_a, sv_a, fs_a, fe_a, if_a.load_ready, busy_a} !==
          {exp_bit, 1'b1, k == 0 || k == 8, k == 7 || k == 15, exp_rdy, 1'b1}) begin
        n_err++;
        $display("FAIL b2b_slot%0d: got %b want %b", k,
                 {so_a, sv_a, fs_a, fe_a, if_a.load_ready, busy_a},
                 {exp_bit, 1'b1, k == 0 || k == 8, k == 7 || k == 15, exp_rdy, 1'b1});
      end
    end
    tick();
    n_vec++;
    if ({sv_a, busy_a} !== 2'b00) begin
      n_err++;
      $display("FAIL b2b_idle: got %b want %b", {sv_a, busy_a}, 2'b00);
    end
  endtask

  task automatic test_slow_tick();
    int b;
    int nvalid = 0;
    sen_c = 1'b0;
    if_c.load_valid = 1'b1;
    if_c.load_data  = 12'h800;
    tick();
    if_c.load_valid = 1'b0;
    n_vec++;
    if ({sv_c, if_c.load_ready, busy_c} !== 3'b001) begin
      n_err++;
      $display("FAIL slow_accept: got %b want %b",
               {sv_c, if_c.load_ready, busy_c}, 3'b001);
    end
    for (int c = 0; c < 56; c++) begin
      sen_c = (c % 4 == 0);
      tick();
      if (sv_c) nvalid++;
      b = c / 4;
      n_vec++;
      if (c < 48) begin
        if ({so_c, sv_c, fs_c, fe_c} !== {b == 0, 1'b1, b == 0, b == 11}) begin
          n_err++;
          $display("FAIL slow_c%0d: got %b want %b", c,
                   {so_c, sv_c, fs_c, fe_c}, {b == 0, 1'b1, b == 0, b == 11});
        end
      end else begin
        if ({so_c, sv_c, fs_c, fe_c, busy_c} !== 5'b00000) begin
          n_err++;
          $display("FAIL slow_idle_c%0d: got %b want %b", c,
                   {so_c, sv_c, fs_c, fe_c, busy_c}, 5'b00000);
        end
      end
    end
    sen_c = 1'b0;
    n_vec++;
    if (nvalid != 48) begin
      n_err++;
      $display("FAIL slow_valid_cycles: got %0d want %0d", nvalid, 48);
    end
  endtask

  task automatic test_clr();
    logic [7:0] w = 8'h3C;
    sen_a = 1'b1;
    if_a.load_valid = 1'b1;
    if_a.load_data  = w;
    tick();
    if_a.load_data = 8'hC3;
    tick();
    tick();
    if_a.load_valid = 1'b0;
    tick();
    tick();
    n_vec++;
    if ({so_a, sv_a, fs_a, fe_a, if_a.load_ready, busy_a} !== {w[4], 5'b10001}) begin
      n_err++;
      $display("FAIL clr_pre: got %b want %b",
               {so_a, sv_a, fs_a, fe_a, if_a.load_ready, busy_a}, {w[4], 5'b10001});
    end
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    n_vec++;
    if ({so_a, sv_a, fs_a, fe_a, if_a.load_ready, busy_a} !== 6'b000010) begin
      n_err++;
      $display("FAIL clr_idle: got %b want %b",
               {so_a, sv_a, fs_a, fe_a, if_a.load_ready, busy_a}, 6'b000010);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      n_vec++;
      if ({sv_a, busy_a} !== 2'b00) begin
        n_err++;
        $display("FAIL clr_after%0d: got %b want %b", i, {sv_a, busy_a}, 2'b00);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clr_a = 1'b0; sen_a = 1'b0;
    clr_b = 1'b0; sen_b = 1'b0;
    clr_c = 1'b0; sen_c = 1'b0;
    if_a.load_valid = 1'b0; if_a.load_data = '0;
    if_b.load_valid = 1'b0; if_b.load_data = '0;
    if_c.load_valid = 1'b0; if_c.load_data = '0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_slow_tick();
    test_clr();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
